// File: rtl/wb_load_unit.sv
// wb_load_unit: writeback stage feeding the register file write port.
// ALU results are written the cycle after acceptance; loads run a
// req/gnt/rvalid handshake with data memory and extend the returned data.
// Optional feature macro: WB_TIMEOUT_EN (bounds the time spent in WAIT).
module wb_load_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    input  logic [DATA_WIDTH-1:0] in_result,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy,
    output logic                  err_misaligned,
    output logic                  err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0]   rf_rd_q, rf_rd_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
    logic                    err_mis_q, err_mis_d;
    logic [1:0]              off_q, off_d;
    logic [2:0]              f3_q, f3_d;
    logic [ADDR_WIDTH-1:0]   ld_rd_q, ld_rd_d;
    logic                    ld_wen_q, ld_wen_d;
    logic                    f3_legal;
    logic                    addr_misaligned;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   ld_data;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = 16;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_to_q, err_to_d;
`endif

    assign in_ready       = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign rf_wen         = rf_wen_q;
    assign rf_rd          = rf_rd_q;
    assign rf_wdata       = rf_wdata_q;
    assign err_misaligned = err_mis_q;
`ifdef WB_TIMEOUT_EN
    assign err_timeout    = err_to_q;
`else
    assign err_timeout    = 1'b0;
`endif

    // Classify the incoming load: legal funct3 and natural alignment.
    always_comb begin
        f3_legal = 1'b0;
        case (in_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                f3_legal = 1'b0;
        endcase
        addr_misaligned = ((in_funct3[1:0] == 2'b01) && in_result[0]) ||
                          ((in_funct3 == 3'b010) && (in_result[1:0] != 2'b00));
    end

    // Select and extend the returned data using the latched offset/type.
    always_comb begin
        ld_byte = mem_rdata[8*off_q +: 8];
        ld_half = mem_rdata[16*off_q[1] +: 16];
        case (f3_q)
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // Next-state and registered-output logic; pulses default low each cycle.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        rf_wen_d   = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        err_mis_d  = 1'b0;
        off_d      = off_q;
        f3_d       = f3_q;
        ld_rd_d    = ld_rd_q;
        ld_wen_d   = ld_wen_q;
`ifdef WB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_to_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!in_is_load) begin
                        rf_wen_d   = in_wen && (in_rd != '0);
                        rf_rd_d    = in_rd;
                        rf_wdata_d = in_result;
                    end else if (!f3_legal || addr_misaligned) begin
                        err_mis_d = 1'b1;
                    end else begin
                        state_d    = S_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {in_result[DATA_WIDTH-1:2], 2'b00};
                        off_d      = in_result[1:0];
                        f3_d       = in_funct3;
                        ld_rd_d    = in_rd;
                        ld_wen_d   = in_wen;
                    end
                end
            end
            S_REQ: begin
                // rvalid is deliberately not looked at until WAIT.
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = S_WAIT;
`ifdef WB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    rf_wen_d   = ld_wen_q && (ld_rd_q != '0);
                    rf_rd_d    = ld_rd_q;
                    rf_wdata_d = ld_data;
                    state_d    = S_IDLE;
                end
`ifdef WB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any load in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rf_wen_q   <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            err_mis_q  <= 1'b0;
            off_q      <= '0;
            f3_q       <= '0;
            ld_rd_q    <= '0;
            ld_wen_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt_q      <= '0;
            err_to_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rf_wen_q   <= rf_wen_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            err_mis_q  <= err_mis_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            ld_rd_q    <= ld_rd_d;
            ld_wen_q   <= ld_wen_d;
`ifdef WB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_to_q   <= err_to_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_load_unit.sv
// Bench for wb_load_unit: ALU vector table, directed load sequences,
// randomized loads against a reference model, reset and WAIT-bound cases.
module tb_wb_load_unit;

`ifdef WB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic        in_wen = 1'b0;
    logic [31:0] in_result = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        err_misaligned;
    logic        err_timeout;

    int n_pass  = 0;
    int n_total = 0;

    wb_load_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_rd(in_rd), .in_wen(in_wen), .in_result(in_result),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy),
        .err_misaligned(err_misaligned), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference: what the architecture says a load returns.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        longint v;
        longint w;
        int off;
        w   = longint'(word);
        off = int'(addr % 4);
        case (f3)
            3'd0: begin v = (w >> (8 * off)) % 256; if (v >= 128) v = v - 256; end
            3'd1: begin v = (w >> (16 * (off / 2))) % 65536; if (v >= 32768) v = v - 65536; end
            3'd4: v = (w >> (8 * off)) % 256;
            3'd5: v = (w >> (16 * (off / 2))) % 65536;
            default: v = w;
        endcase
        return 32'(v);
    endfunction

    function automatic bit ref_rejects(input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        if (!legal) return 1'b1;
        if ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) return 1'b1;
        if (f3 == 2 && (addr % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    // Full load transaction with configurable grant/rvalid latency.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic wen, input logic [31:0] word,
                           input int gnt_dly, input int rv_dly, input bit noise);
        logic [31:0] exp_data;
        logic        exp_wen;
        in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = f3; in_rd = rd;
        in_wen = wen; in_result = addr;
        step();
        in_valid = 1'b0; in_result = $urandom; in_rd = 5'($urandom);
        if (ref_rejects(f3, addr)) begin
            chk({tag, " err_mis"}, 32'(err_misaligned), 32'd1);
            chk({tag, " rej req"}, 32'(mem_req), 32'd0);
            chk({tag, " rej rdy"}, 32'(in_ready), 32'd1);
            chk({tag, " rej wen"}, 32'(rf_wen), 32'd0);
            step();
            chk({tag, " err pulse"}, 32'(err_misaligned), 32'd0);
            return;
        end
        exp_data = ref_load(f3, addr, word);
        exp_wen  = wen && (rd != 0);
        chk({tag, " req"}, 32'(mem_req), 32'd1);
        chk({tag, " addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        chk({tag, " no err"}, 32'(err_misaligned), 32'd0);
        for (int i = 0; i < gnt_dly; i++) begin
            if (noise) begin mem_rvalid = 1'b1; mem_rdata = $urandom; end
            step();
            chk({tag, " req hold"}, 32'(mem_req), 32'd1);
            chk({tag, " addr hold"}, mem_addr, addr & 32'hFFFF_FFFC);
            chk({tag, " stall"}, {30'd0, busy, in_ready}, 32'd2);
            chk({tag, " no early wen"}, 32'(rf_wen), 32'd0);
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk({tag, " req drop"}, 32'(mem_req), 32'd0);
        chk({tag, " wait busy"}, {30'd0, busy, in_ready}, 32'd2);
        for (int i = 0; i < rv_dly; i++) begin
            step();
            chk({tag, " wait wen"}, 32'(rf_wen), 32'd0);
        end
        mem_rvalid = 1'b1; mem_rdata = word;
        step();
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        chk({tag, " wen"}, 32'(rf_wen), 32'(exp_wen));
        if (exp_wen) begin
            chk({tag, " rd"}, 32'(rf_rd), 32'(rd));
            chk({tag, " data"}, rf_wdata, exp_data);
        end
        chk({tag, " ready"}, {30'd0, busy, in_ready}, 32'd1);
        step();
        chk({tag, " wen pulse"}, 32'(rf_wen), 32'd0);
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
        logic        exp_wen;
    } alu_vec_t;

    alu_vec_t alu_tab[6];

    initial begin
        int pulses;
        alu_tab[0] = '{5'd3,  1'b1, 32'h0000_0011, 1'b1};
        alu_tab[1] = '{5'd4,  1'b1, 32'h0000_0022, 1'b1};
        alu_tab[2] = '{5'd0,  1'b1, 32'hDEAD_BEEF, 1'b0};
        alu_tab[3] = '{5'd5,  1'b0, 32'h1234_5678, 1'b0};
        alu_tab[4] = '{5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1};
        alu_tab[5] = '{5'd1,  1'b1, 32'h0000_0000, 1'b1};

        // Reset state
        step(); step();
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst mem", {31'd0, mem_req} | mem_addr, 32'd0);
        chk("rst rf", {26'd0, rf_wen, rf_rd} | rf_wdata, 32'd0);
        chk("rst err", {30'd0, err_misaligned, err_timeout}, 32'd0);
        rst = 1'b0;
        step();

        // Back-to-back ALU writebacks from the table
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_is_load = 1'b0; in_rd = alu_tab[i].rd;
            in_wen = alu_tab[i].wen; in_result = alu_tab[i].data; in_funct3 = 3'($urandom);
            step();
            chk($sformatf("alu%0d wen", i), 32'(rf_wen), 32'(alu_tab[i].exp_wen));
            chk($sformatf("alu%0d rd", i), 32'(rf_rd), 32'(alu_tab[i].rd));
            chk($sformatf("alu%0d data", i), rf_wdata, alu_tab[i].data);
            chk($sformatf("alu%0d ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("alu idle wen", 32'(rf_wen), 32'd0);

        // Directed loads
        do_load("lb1003", 3'd0, 32'h0000_1003, 5'd6, 1'b1, 32'h80FF_0000, 0, 1, 1'b0);
        do_load("lhu2002", 3'd5, 32'h0000_2002, 5'd7, 1'b1, 32'h8001_1234, 0, 0, 1'b0);
        do_load("lh2002", 3'd1, 32'h0000_2002, 5'd8, 1'b1, 32'h8001_1234, 0, 0, 1'b0);
        do_load("lw2002", 3'd2, 32'h0000_2002, 5'd9, 1'b1, 32'h8001_1234, 0, 0, 1'b0);
        do_load("gnt3", 3'd2, 32'h0000_4000, 5'd10, 1'b1, 32'hCAFE_F00D, 3, 2, 1'b1);
        do_load("rd0", 3'd2, 32'h0000_5000, 5'd0, 1'b1, 32'h1111_2222, 1, 1, 1'b0);
        do_load("wen0", 3'd4, 32'h0000_5001, 5'd12, 1'b0, 32'h1111_2222, 0, 1, 1'b0);
        do_load("ill3", 3'd3, 32'h0000_6000, 5'd13, 1'b1, 32'h0, 0, 0, 1'b0);
        do_load("ill7", 3'd7, 32'h0000_6000, 5'd13, 1'b1, 32'h0, 0, 0, 1'b0);
        do_load("lhu1", 3'd5, 32'h0000_6001, 5'd13, 1'b1, 32'h0, 0, 0, 1'b0);

        // Randomized mix of ALU results and loads
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] w;
            logic [4:0]  rd;
            logic        wen;
            f3 = 3'($urandom); a = $urandom; w = $urandom;
            rd = 5'($urandom); wen = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_wen = wen; in_result = a;
                step();
                in_valid = 1'b0;
                chk($sformatf("r%0d alu wen", i), 32'(rf_wen), 32'(wen && rd != 0));
                chk($sformatf("r%0d alu data", i), rf_wdata, a);
            end else begin
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                do_load($sformatf("r%0d", i), f3, a, rd, wen, w,
                        $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            end
        end

        // Reset while in WAIT, then a stray rvalid in IDLE
        in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'd2; in_rd = 5'd14;
        in_wen = 1'b1; in_result = 32'h0000_7000;
        step();
        in_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("rstw busy", {30'd0, busy, in_ready}, 32'd1);
        chk("rstw mem", {31'd0, mem_req} | mem_addr, 32'd0);
        chk("rstw rf", {26'd0, rf_wen, rf_rd} | rf_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        chk("late rv wen", 32'(rf_wen), 32'd0);
        chk("late rv data", rf_wdata, 32'd0);
        chk("late rv ready", 32'(in_ready), 32'd1);

        // WAIT without rvalid
        in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'd2; in_rd = 5'd15;
        in_wen = 1'b1; in_result = 32'h0000_8000;
        step();
        in_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
`ifdef WB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            chk($sformatf("to wait%0d", i), {29'd0, err_timeout, busy, in_ready}, 32'd2);
            step();
        end
        chk("to pulse", {29'd0, err_timeout, busy, in_ready}, 32'd5);
        chk("to no wen", 32'(rf_wen), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        chk("to late rv", {30'd0, rf_wen, err_timeout}, 32'd0);
`else
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            if (err_timeout) pulses++;
            step();
        end
        chk("nto pulses", 32'(pulses), 32'd0);
        chk("nto still busy", {30'd0, busy, in_ready}, 32'd2);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        chk("nto wen", 32'(rf_wen), 32'd1);
        chk("nto data", rf_wdata, 32'h5555_AAAA);
`endif
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_load_unit.md
Name: wb_load_unit

Overview:
- Writeback stage sitting directly upstream of the NPC register file.
- Takes one result per transaction from execute: either an ALU result, or a load address.
- For loads, it runs a request/grant/rvalid handshake with data memory and sign- or zero-extends the returned byte, half or word.
- Drives the register file write port (rf_wen/rf_rd/rf_wdata) with registered outputs and stalls execute through in_ready while a load is outstanding.

Parameters:
ADDR_WIDTH, 5, register index width; matches the register file.
DATA_WIDTH, 32, datapath width; load extraction is defined only for 32.
TIMEOUT, 255, maximum cycles spent in WAIT; used only with WB_TIMEOUT_EN.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  execute presents a result.
in_ready  output  1  unit accepts; high only in IDLE.
in_is_load  input  1  1 = load (in_result is the address); 0 = ALU writeback.
in_funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
in_rd  input  ADDR_WIDTH  destination register.
in_wen  input  1  instruction writes rd.
in_result  input  DATA_WIDTH  ALU result or load address.
mem_req  output  1  read request; held until granted.
mem_addr  output  DATA_WIDTH  word-aligned address, {addr[31:2],2'b00}.
mem_gnt  input  1  request accepted this cycle.
mem_rvalid  input  1  read data valid.
mem_rdata  input  DATA_WIDTH  read word.
rf_wen  output  1  register file write enable; one-cycle pulse.
rf_rd  output  ADDR_WIDTH  register file write address.
rf_wdata  output  DATA_WIDTH  register file write data.
busy  output  1  high whenever state != IDLE.
err_misaligned  output  1  one-cycle pulse on a misaligned or illegal load.
err_timeout  output  1  one-cycle pulse on load timeout; tied 0 without WB_TIMEOUT_EN.

Behaviour:
- Reset:
  - State returns to IDLE.
  - All outputs registered 0: mem_req, mem_addr, rf_wen, rf_rd, rf_wdata, err_*.
  - busy=0; in_ready goes to 1 in IDLE.
  - Reset mid-load abandons the load. A late mem_rvalid arriving in IDLE is ignored.
- States:
  - IDLE: in_ready=1.
  - REQ: mem_req=1; mem_addr held stable.
  - WAIT: waiting for mem_rvalid.
- Handshake: a transfer occurs when in_valid && in_ready at a posedge. All transaction fields are captured at that edge.
- Non-load, accepted at edge N:
  - rf_wen = in_wen && (in_rd != 0), asserted during cycle N+1.
  - rf_rd = in_rd; rf_wdata = in_result.
  - State stays IDLE, so back-to-back ALU results give one write per cycle.
- Load, accepted at edge N:
  - Misaligned if lh/lhu with addr[0]=1, or lw with addr[1:0]!=0.
  - Illegal if funct3 is not one of the five listed codes.
  - On misaligned or illegal: no memory request, err_misaligned=1 during N+1, no rf write, stay IDLE.
  - Otherwise: enter REQ with mem_req=1 in N+1. The address offset and funct3 are latched.
- REQ: on mem_gnt, mem_req drops next cycle and the state moves to WAIT. mem_rvalid is ignored in REQ; earliest legal rvalid is the cycle after gnt.
- WAIT: on mem_rvalid at edge M:
  - Extract using the latched offset:
    - byte = rdata[8*off +: 8]
    - half = rdata[16*off[1] +: 16]
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through unchanged.
  - rf_wen (gated by wen and rd!=0) is asserted during M+1, with rf_rd/rf_wdata valid.
  - State returns to IDLE, so in_ready=1 during M+1.
- Load with rd=0 or wen=0: the memory transaction still completes; rf_wen stays 0.
- rf_wen, err_misaligned and err_timeout are each high for exactly one cycle per event.

Optional Feature:
- WB_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entry to WAIT and increments each WAIT cycle without rvalid.
  - When the count reaches TIMEOUT, err_timeout=1 for one cycle, no rf write, return to IDLE.
  - A later rvalid is ignored.
- Without it: no counter; WAIT waits indefinitely; err_timeout is constant 0.

Test Plan:
- ALU back-to-back: rd=3 data 0x11 at N, rd=4 data 0x22 at N+1 -> rf_wen in N+1 (rd 3, 0x11) and N+2 (rd 4, 0x22); in_ready stays 1.
- lb at addr 0x1003, gnt immediately, rvalid 2 cycles later with rdata 0x80FF_0000 -> rf_wdata 0xFFFF_FF80; mem_addr 0x1000.
- lhu at 0x2002, rdata 0x8001_1234 -> 0x0000_8001. lh at the same address -> 0xFFFF_8001. Then lw at 0x2002 -> err_misaligned pulse, mem_req stays 0.
- mem_gnt withheld 3 cycles -> mem_req and mem_addr held stable; busy=1 and in_ready=0 throughout.
- Load to rd=0 -> memory transaction completes, rf_wen never asserted. Separately, rst asserted in WAIT then rvalid arrives -> no rf write, outputs 0.
- With WB_TIMEOUT_EN and TIMEOUT=4, no rvalid -> err_timeout after 4 WAIT cycles, state returns to IDLE, in_ready=1.
